// File: rtl/lsu.sv
// lsu: load/store unit between the ALU and data memory.
//
// Takes the ALU result as the effective address for LB/LH/LW/LBU/LHU/SB/SH/SW.
// It then runs one request/acknowledge transaction to data memory. While that
// transaction is open, the unit stalls the core.
//
// Ports
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_valid, i_we          access request (held while o_stall), 1=store
//   i_funct3, i_addr       instruction funct3, effective address
//   i_st_data              rs2 value for stores
//   o_stall                combinational stall to the core
//   o_done, o_err          one-cycle completion pulse and status
//                          (00 ok, 01 misaligned, 10 illegal, 11 timeout)
//   o_ld_data              extended load result
//   o_mem_req/we/addr/be/wdata, i_mem_ack, i_mem_rdata   memory port
module lsu #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_st_data,
    output logic        o_stall,
    output logic        o_done,
    output logic [1:0]  o_err,
    output logic [31:0] o_ld_data,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;

    logic        is_illegal, is_misaligned;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] ld_ext;

    logic        capture;
    logic        req_d, done_d, ld_upd;
    logic [1:0]  err_d;
    logic [31:0] ld_d;

    // Request decode from the live core inputs.
    always_comb begin
        if (i_we)
            is_illegal = i_funct3[2] || (i_funct3[1:0] == 2'b11);
        else
            is_illegal = (i_funct3 == 3'b011) || (i_funct3[2:1] == 2'b11);

        is_misaligned = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                        ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));

        case (i_funct3[1:0])
            2'b00:   be_c = 4'b0001 << i_addr[1:0];
            2'b01:   be_c = i_addr[1] ? 4'b1100 : 4'b0011;
            default: be_c = 4'b1111;
        endcase

        wdata_c = '0;
        if (i_we) begin
            case (i_funct3[1:0])
                2'b00:   wdata_c = {4{i_st_data[7:0]}};
                2'b01:   wdata_c = {2{i_st_data[15:0]}};
                default: wdata_c = i_st_data;
            endcase
        end
    end

    // Load alignment and extension from the registered offset.
    always_comb begin
        byte_v = i_mem_rdata[{off_q, 3'b000} +: 8];
        half_v = i_mem_rdata[{off_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'b000:  ld_ext = {{24{byte_v[7]}}, byte_v};
            3'b001:  ld_ext = {{16{half_v[15]}}, half_v};
            3'b100:  ld_ext = {24'h0, byte_v};
            3'b101:  ld_ext = {16'h0, half_v};
            default: ld_ext = i_mem_rdata;
        endcase
    end

    assign o_stall = ((state_q == IDLE) && i_valid) || (state_q == BUSY);

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        capture = 1'b0;
        req_d   = o_mem_req;
        done_d  = 1'b0;
        err_d   = o_err;
        ld_upd  = 1'b0;
        ld_d    = '0;

        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    capture = 1'b1;
                    if (is_illegal || is_misaligned) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = is_illegal ? 2'b10 : 2'b01;
                        ld_upd  = 1'b1;
                    end else begin
                        state_d = BUSY;
                        req_d   = 1'b1;
                        tmo_d   = '0;
                    end
                end
            end
            BUSY: begin
                if (i_mem_ack) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 2'b00;
                    ld_upd  = 1'b1;
                    ld_d    = we_q ? '0 : ld_ext;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 2'b11;
                    ld_upd  = 1'b1;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            tmo_q       <= '0;
            we_q        <= 1'b0;
            funct3_q    <= '0;
            off_q       <= '0;
            o_done      <= 1'b0;
            o_err       <= '0;
            o_ld_data   <= '0;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_be    <= '0;
            o_mem_wdata <= '0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            o_mem_req <= req_d;
            o_done    <= done_d;
            o_err     <= err_d;
            if (ld_upd)
                o_ld_data <= ld_d;
            if (capture) begin
                we_q        <= i_we;
                funct3_q    <= i_funct3;
                off_q       <= i_addr[1:0];
                o_mem_we    <= i_we;
                o_mem_addr  <= {i_addr[31:2], 2'b00};
                o_mem_be    <= be_c;
                o_mem_wdata <= wdata_c;
            end
        end
    end

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0;
    logic [31:0] st_data = '0;
    logic        stall, done;
    logic [1:0]  err;
    logic [31:0] ld_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    int unsigned total = 0;
    int unsigned bad = 0;

    typedef struct packed {
        logic [1:0]  err;
        logic [31:0] ld;
    } exp_t;
    exp_t sb[$];

    lsu #(.ACK_TIMEOUT(4)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (valid),
        .i_we       (we),
        .i_funct3   (funct3),
        .i_addr     (addr),
        .i_st_data  (st_data),
        .o_stall    (stall),
        .o_done     (done),
        .o_err      (err),
        .o_ld_data  (ld_data),
        .o_mem_req  (mem_req),
        .o_mem_we   (mem_we),
        .o_mem_addr (mem_addr),
        .o_mem_be   (mem_be),
        .o_mem_wdata(mem_wdata),
        .i_mem_ack  (mem_ack),
        .i_mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One access. ack_at = BUSY cycle in which ack is given (0 = never).
    task automatic access(input string tag, input logic w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] st, input logic [31:0] rd,
                          input int ack_at, input logic [1:0] e_err, input logic [31:0] e_ld,
                          input logic [3:0] e_be, input logic [31:0] e_wd,
                          input int e_req, input int e_lat);
        int cyc;
        int reqs;
        exp_t ex;
        logic [31:0] held;
        @(posedge clk); #1;
        valid = 1'b1; we = w; funct3 = f3; addr = a; st_data = st;
        sb.push_back('{err: e_err, ld: e_ld});
        #1 check({tag, "_stall0"}, 32'(stall), 32'd1);
        cyc = 0; reqs = 0;
        while (1) begin
            @(posedge clk); #1;
            cyc++;
            mem_ack = 1'b0;
            if (done) break;
            if (mem_req) begin
                reqs++;
                if (reqs == 1) begin
                    check({tag, "_maddr"}, mem_addr, {a[31:2], 2'b00});
                    check({tag, "_mwe"}, 32'(mem_we), 32'(w));
                    check({tag, "_be"}, 32'(mem_be), 32'(e_be));
                    check({tag, "_wdata"}, mem_wdata, e_wd);
                end
                if (reqs == ack_at) begin
                    mem_ack = 1'b1;
                    mem_rdata = rd;
                end
            end
            if (cyc > 40) begin
                check({tag, "_no_done"}, 32'd0, 32'd1);
                break;
            end
        end
        if (done) begin
            if (sb.size() == 0) begin
                check({tag, "_sb_empty"}, 32'd0, 32'd1);
            end else begin
                ex = sb.pop_front();
                check({tag, "_err"}, 32'(err), 32'(ex.err));
                check({tag, "_ld"}, ld_data, ex.ld);
            end
            check({tag, "_lat"}, 32'(cyc), 32'(e_lat));
            check({tag, "_reqs"}, 32'(reqs), 32'(e_req));
            check({tag, "_stall_done"}, 32'(stall), 32'd0);
            check({tag, "_req_done"}, 32'(mem_req), 32'd0);
        end
        held = ld_data;
        // valid stays high through DONE; it belongs to the finished instruction
        @(posedge clk); #1;
        valid = 1'b0;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_ld_hold"}, ld_data, held);
    endtask

    initial begin
        #12;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_ld", ld_data, 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_mem", {mem_addr[31:1], mem_we} | mem_wdata | 32'(mem_be), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        access("lw", 1'b0, 3'b010, 32'h1004, '0, 32'hDEADBEEF, 1, 2'b00, 32'hDEADBEEF, 4'hF, 32'h0, 1, 2);
        access("lb0", 1'b0, 3'b000, 32'h2000, '0, 32'h80FF7F01, 1, 2'b00, 32'h00000001, 4'h1, 32'h0, 1, 2);
        access("lb1", 1'b0, 3'b000, 32'h2001, '0, 32'h80FF7F01, 1, 2'b00, 32'h0000007F, 4'h2, 32'h0, 1, 2);
        access("lb2", 1'b0, 3'b000, 32'h2002, '0, 32'h80FF7F01, 2, 2'b00, 32'hFFFFFFFF, 4'h4, 32'h0, 2, 3);
        access("lb3", 1'b0, 3'b000, 32'h2003, '0, 32'h80FF7F01, 1, 2'b00, 32'hFFFFFF80, 4'h8, 32'h0, 1, 2);
        access("lbu3", 1'b0, 3'b100, 32'h2003, '0, 32'h80FF7F01, 1, 2'b00, 32'h00000080, 4'h8, 32'h0, 1, 2);
        access("lh2", 1'b0, 3'b001, 32'h2002, '0, 32'h80FF7F01, 1, 2'b00, 32'hFFFF80FF, 4'hC, 32'h0, 1, 2);
        access("lhu0", 1'b0, 3'b101, 32'h2000, '0, 32'h80FF7F01, 1, 2'b00, 32'h00007F01, 4'h3, 32'h0, 1, 2);
        access("sb3", 1'b1, 3'b000, 32'h3003, 32'h12345678, 32'hFFFFFFFF, 2, 2'b00, 32'h0, 4'h8, 32'h78787878, 2, 3);
        access("sh2", 1'b1, 3'b001, 32'h3002, 32'h12345678, 32'h0, 1, 2'b00, 32'h0, 4'hC, 32'h56785678, 1, 2);
        access("sw", 1'b1, 3'b010, 32'h3000, 32'h12345678, 32'h0, 1, 2'b00, 32'h0, 4'hF, 32'h12345678, 1, 2);
        access("lw_pre", 1'b0, 3'b010, 32'h1000, '0, 32'hCAFEF00D, 1, 2'b00, 32'hCAFEF00D, 4'hF, 32'h0, 1, 2);
        access("lw_mis", 1'b0, 3'b010, 32'h1002, '0, '0, 1, 2'b01, 32'h0, 4'h0, 32'h0, 0, 1);
        access("sh_mis", 1'b1, 3'b001, 32'h1001, 32'h12345678, '0, 1, 2'b01, 32'h0, 4'h0, 32'h0, 0, 1);
        access("ld_ill", 1'b0, 3'b011, 32'h1000, '0, '0, 1, 2'b10, 32'h0, 4'h0, 32'h0, 0, 1);
        access("st_ill", 1'b1, 3'b100, 32'h1000, 32'h1, '0, 1, 2'b10, 32'h0, 4'h0, 32'h0, 0, 1);
        access("ill_prio", 1'b1, 3'b101, 32'h1001, 32'h1, '0, 1, 2'b10, 32'h0, 4'h0, 32'h0, 0, 1);
        access("tmo", 1'b0, 3'b010, 32'h4000, '0, '0, 0, 2'b11, 32'h0, 4'hF, 32'h0, 4, 5);
        access("ack4", 1'b0, 3'b010, 32'h4000, '0, 32'h0BADC0DE, 4, 2'b00, 32'h0BADC0DE, 4'hF, 32'h0, 4, 5);

        // stray ack while idle
        @(posedge clk); #1;
        mem_ack = 1'b1; mem_rdata = 32'h55555555;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        check("stray_req", 32'(mem_req), 32'd0);
        check("stray_done", 32'(done), 32'd0);
        check("stray_stall", 32'(stall), 32'd0);
        check("stray_ld", ld_data, 32'h0BADC0DE);

        // reset in the second BUSY cycle
        @(posedge clk); #1;
        valid = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h5000;
        @(posedge clk); #1;
        check("rbusy_req1", 32'(mem_req), 32'd1);
        @(posedge clk); #1;
        check("rbusy_req2", 32'(mem_req), 32'd1);
        rst_n = 1'b0; valid = 1'b0;
        #1;
        check("rbusy_req_drop", 32'(mem_req), 32'd0);
        check("rbusy_stall_drop", 32'(stall), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (i == 1) rst_n = 1'b1;
            check("rbusy_no_done", 32'(done), 32'd0);
        end
        access("post_rst", 1'b0, 3'b010, 32'h1004, '0, 32'h13579BDF, 1, 2'b00, 32'h13579BDF, 4'hF, 32'h0, 1, 2);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
